fetch_unit_r32i: RTL
====================

Name: fetch_unit_r32i

Overview:
- Instruction fetch stage directly upstream of the RV32I decoder.
- Owns the program counter and issues single-outstanding word requests to instruction memory.
- Holds the returned instruction as rawIns for the decoder and presents its PC as ProgAddr.
- Applies branch/jump redirects from the decoder's PC-control outputs when the held instruction is consumed.

Parameters:
- dataW, 32: instruction/address width; only 32 is supported.
- ResetPC, 32'h0000_0000: PC fetched first after reset; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- ImemReq  output  1  request valid to instruction memory.
- ImemAddr  output  dataW  word-aligned fetch address.
- ImemAck  input  1  memory returns data this cycle.
- ImemData  input  dataW  instruction word; valid when ImemAck=1.
- rawIns  output  dataW  held instruction, to decoder.
- InsValid  output  1  rawIns/ProgAddr are valid.
- InsReady  input  1  downstream consumes the held instruction this cycle.
- ProgAddr  output  dataW  PC of the held instruction.
- LinkAddr  output  dataW  ProgAddr+4, the return address for JAL/JALR.
- TestBranch  input  1  from decoder: conditional branch.
- AlwaysBranch  input  1  from decoder: unconditional jump.
- AbsoluteBranch  input  1  from decoder: target is absolute.
- BranchCond  input  1  from condition generator: condition true.
- BranchAddr  input  dataW  ALU result used as branch target or offset.
- Misaligned  output  1  sticky fault: a taken target was not word aligned.

Behaviour:
- Reset (asynchronous, nReset=0) forces the following values; all outputs are registered except LinkAddr.
  - State IDLE, PC=ResetPC.
  - ImemReq=0, ImemAddr=ResetPC, rawIns=0, InsValid=0, ProgAddr=0, Misaligned=0.
- Reset asserted mid-operation discards any in-flight request.
  - An ImemAck arriving during or after reset, while the state is not FETCH, is ignored.
- IDLE -> FETCH unconditionally on the first clk edge after reset release. ImemReq=1 and ImemAddr=PC from that edge.
- FETCH:
  - ImemReq and ImemAddr are held stable until ImemAck=1.
  - On the ImemAck edge: rawIns<=ImemData, ProgAddr<=PC, InsValid<=1, ImemReq<=0, state->VALID.
  - InsReady is ignored in FETCH.
- VALID:
  - rawIns and ProgAddr are held stable while InsReady=0, for any number of cycles.
  - Decoder and branch inputs are sampled only on the edge where InsReady=1.
  - taken = AlwaysBranch | (TestBranch & BranchCond).
  - next = taken ? (AbsoluteBranch ? {BranchAddr[31:1],1'b0} : ProgAddr+BranchAddr) : ProgAddr+4.
  - All additions are modulo 2^32; wrap from 32'hFFFF_FFFC+4 to 0 is legal.
  - If next[1]=1: Misaligned<=1, InsValid<=0, state->FAULT, PC unchanged.
  - Otherwise: PC<=next, ImemAddr<=next, ImemReq<=1, InsValid<=0, state->FETCH.
- FAULT:
  - Terminal state. ImemReq=0, InsValid=0, Misaligned=1; exited only by reset.
  - rawIns and ProgAddr keep the faulting instruction for debug.
- Latency and throughput:
  - ImemAck to InsValid: 1 cycle.
  - InsReady to next ImemReq: 1 cycle.
  - Peak rate is 1 instruction per 2 cycles with zero-wait memory.
- Only one request is ever outstanding, so no flush logic is required.
- TestBranch=1 with AlwaysBranch=1 resolves as taken.
- AbsoluteBranch is ignored when not taken.
- X on branch inputs while InsReady=0 must not propagate into any state.

Test Plan:
- Reset release, zero-wait memory returning 32'h00000013 (NOP) each request -> ImemAddr sequence 0,4,8,C; InsValid pulses every 2nd cycle; LinkAddr=ProgAddr+4.
- Memory holds ImemAck=0 for 5 cycles at addr 8 -> ImemReq/ImemAddr=8 stable for all 5 cycles; InsValid stays 0; captures on the 6th cycle.
- Held instruction at 32'h10, InsReady=0 for 3 cycles then 1 -> rawIns and ProgAddr unchanged throughout; next ImemAddr=32'h14.
- BRANCH at 32'h20, TestBranch=1, BranchAddr=32'hFFFF_FFF0, BranchCond=1 -> next ImemAddr=32'h10; same with BranchCond=0 -> 32'h24.
- JALR at 32'h40, AlwaysBranch=AbsoluteBranch=1, BranchAddr=32'h0000_0101 -> ImemAddr=32'h100. With BranchAddr=32'h0000_0102 -> Misaligned=1, ImemReq stays 0 until reset.
- nReset pulsed low while in FETCH at addr 32'h30 with a late ImemAck -> outputs return to reset values immediately; after release the first ImemAddr is ResetPC; the stale ack is not captured.

Source files
------------

// File: rtl/fetch_unit_r32i.sv
// Instruction fetch stage for an RV32I core.
// Owns the PC and keeps at most one word request outstanding to instruction
// memory. It holds the returned word for the decoder and resolves the next PC
// from the decoder's branch controls when that word is consumed. A taken
// target whose bit 1 is set latches a sticky fault that only reset clears.
module fetch_unit_r32i #(
  parameter int          dataW   = 32,
  parameter logic [31:0] ResetPC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             nReset,
  output logic             ImemReq,
  output logic [dataW-1:0] ImemAddr,
  input  logic             ImemAck,
  input  logic [dataW-1:0] ImemData,
  output logic [dataW-1:0] rawIns,
  output logic             InsValid,
  input  logic             InsReady,
  output logic [dataW-1:0] ProgAddr,
  output logic [dataW-1:0] LinkAddr,
  input  logic             TestBranch,
  input  logic             AlwaysBranch,
  input  logic             AbsoluteBranch,
  input  logic             BranchCond,
  input  logic [dataW-1:0] BranchAddr,
  output logic             Misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [dataW-1:0] pc_q, pc_d;
  logic             imem_req_q, imem_req_d;
  logic [dataW-1:0] imem_addr_q, imem_addr_d;
  logic [dataW-1:0] raw_ins_q, raw_ins_d;
  logic             ins_valid_q, ins_valid_d;
  logic [dataW-1:0] prog_addr_q, prog_addr_d;
  logic             misaligned_q, misaligned_d;
  logic             taken;
  logic [dataW-1:0] next_pc;

  // Next-state and next-output computation; branch inputs are only looked at
  // inside the VALID/InsReady arm so that garbage on them cannot reach state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    raw_ins_d    = raw_ins_q;
    ins_valid_d  = ins_valid_q;
    prog_addr_d  = prog_addr_q;
    misaligned_d = misaligned_q;
    taken        = 1'b0;
    next_pc      = '0;

    case (state_q)
      ST_IDLE: begin
        state_d     = ST_FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
      end

      ST_FETCH: begin
        if (ImemAck) begin
          raw_ins_d   = ImemData;
          prog_addr_d = pc_q;
          ins_valid_d = 1'b1;
          imem_req_d  = 1'b0;
          state_d     = ST_VALID;
        end
      end

      ST_VALID: begin
        if (InsReady) begin
          taken = AlwaysBranch | (TestBranch & BranchCond);
          if (!taken) begin
            next_pc = prog_addr_q + dataW'(4);
          end else if (AbsoluteBranch) begin
            next_pc = {BranchAddr[dataW-1:1], 1'b0};
          end else begin
            next_pc = prog_addr_q + BranchAddr;
          end

          ins_valid_d = 1'b0;
          if (next_pc[1]) begin
            misaligned_d = 1'b1;
            state_d      = ST_FAULT;
          end else begin
            pc_d        = next_pc;
            imem_addr_d = next_pc;
            imem_req_d  = 1'b1;
            state_d     = ST_FETCH;
          end
        end
      end

      default: begin
        // Terminal fault: keep the faulting word visible, never request again.
        imem_req_d   = 1'b0;
        ins_valid_d  = 1'b0;
        misaligned_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset drops any in-flight request.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ST_IDLE;
      pc_q         <= ResetPC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= ResetPC;
      raw_ins_q    <= '0;
      ins_valid_q  <= 1'b0;
      prog_addr_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      raw_ins_q    <= raw_ins_d;
      ins_valid_q  <= ins_valid_d;
      prog_addr_q  <= prog_addr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign ImemReq    = imem_req_q;
  assign ImemAddr   = imem_addr_q;
  assign rawIns     = raw_ins_q;
  assign InsValid   = ins_valid_q;
  assign ProgAddr   = prog_addr_q;
  assign Misaligned = misaligned_q;
  // Return address is combinational so it tracks ProgAddr without a lag.
  assign LinkAddr   = prog_addr_q + dataW'(4);

endmodule
